// File: rtl/wb_regfile_pkg.sv
// Shared types and default sizes for the writeback register file.
package wb_regfile_pkg;

  // Default register address width (2**ASIZE registers) and data width.
  localparam int unsigned ASIZE_DEFAULT = 5;
  localparam int unsigned DSIZE_DEFAULT = 32;

  // Per-cycle hazard sources seen by the scoreboard for the presented issue.
  typedef struct packed {
    logic raw1;
    logic raw2;
    logic waw;
  } hazard_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the pipeline (writeback/decode) and the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int unsigned ASIZE = ASIZE_DEFAULT,
  parameter int unsigned DSIZE = DSIZE_DEFAULT
) ();

  // Writeback port from the EXE/WB pipeline register.
  logic                    wen;
  logic [ASIZE-1:0]        waddr;
  logic [DSIZE-1:0]        wdata;

  // Decode read ports.
  logic [ASIZE-1:0]        raddr1;
  logic                    ren1;
  logic [DSIZE-1:0]        rdata1;
  logic [ASIZE-1:0]        raddr2;
  logic                    ren2;
  logic [DSIZE-1:0]        rdata2;

  // Decode issue handshake.
  logic                    issue_valid;
  logic                    issue_wen;
  logic [ASIZE-1:0]        issue_addr;
  logic                    stall;
  logic [(2**ASIZE)-1:0]   busy_vec;

  // Pipeline side: drives writeback and decode requests.
  modport master (
    output wen, waddr, wdata,
    output raddr1, ren1, raddr2, ren2,
    output issue_valid, issue_wen, issue_addr,
    input  rdata1, rdata2, stall, busy_vec
  );

  // Register file side.
  modport slave (
    input  wen, waddr, wdata,
    input  raddr1, ren1, raddr2, ren2,
    input  issue_valid, issue_wen, issue_addr,
    output rdata1, rdata2, stall, busy_vec
  );

endinterface

// File: rtl/wb_regfile_reg_scoreboard.sv
// In-flight destination tracking: one busy bit per register, set on issue accept,
// cleared on writeback retire, and combinational RAW/WAW stall generation.
module reg_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int unsigned ASIZE = ASIZE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ASIZE-1:0]      waddr,
  input  logic [ASIZE-1:0]      raddr1,
  input  logic                  ren1,
  input  logic [ASIZE-1:0]      raddr2,
  input  logic                  ren2,
  input  logic                  issue_valid,
  input  logic                  issue_wen,
  input  logic [ASIZE-1:0]      issue_addr,
  output logic                  stall,
  output logic [(2**ASIZE)-1:0] busy_vec
);

  localparam int unsigned NREG = 2 ** ASIZE;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  hazard_t         haz;
  logic            retire;
  logic            accept;

  // R0 is never a real destination, so a write to it retires nothing.
  assign retire = wen && (waddr != '0);

  // Hazard detection; a write retiring this cycle resolves the hazard it would cause.
  always_comb begin
    haz      = '0;
    haz.raw1 = ren1 && (raddr1 != '0) && busy_q[raddr1] && !(wen && (waddr == raddr1));
    haz.raw2 = ren2 && (raddr2 != '0) && busy_q[raddr2] && !(wen && (waddr == raddr2));
    haz.waw  = issue_wen && (issue_addr != '0) && busy_q[issue_addr] &&
               !(wen && (waddr == issue_addr));
    stall    = issue_valid && (|haz);
  end

  assign accept = issue_valid && !stall && issue_wen && (issue_addr != '0);

  // Next busy state: clear on retire first, then set on accept so set wins on a tie.
  always_comb begin
    busy_d = busy_q;
    if (retire) begin
      busy_d[waddr] = 1'b0;
    end
    if (accept) begin
      busy_d[issue_addr] = 1'b1;
    end
  end

  // Busy bit storage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-side register file: storage array, write port and bypassing read ports,
// with the scoreboard that stalls decode on RAW/WAW hazards.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned ASIZE = ASIZE_DEFAULT,
  parameter int unsigned DSIZE = DSIZE_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);

  localparam int unsigned NREG = 2 ** ASIZE;

  logic [DSIZE-1:0] regs_q [NREG];
  logic             do_write;

  // Writes to R0 are discarded so it always reads as zero.
  assign do_write = bus.wen && (bus.waddr != '0);

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (do_write) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Read ports: R0 is zero, a same-cycle write is forwarded, otherwise storage.
  always_comb begin
    bus.rdata1 = regs_q[bus.raddr1];
    if (bus.raddr1 == '0) begin
      bus.rdata1 = '0;
    end else if (bus.wen && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
    end

    bus.rdata2 = regs_q[bus.raddr2];
    if (bus.raddr2 == '0) begin
      bus.rdata2 = '0;
    end else if (bus.wen && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
    end
  end

  reg_scoreboard #(
    .ASIZE (ASIZE)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .wen         (bus.wen),
    .waddr       (bus.waddr),
    .raddr1      (bus.raddr1),
    .ren1        (bus.ren1),
    .raddr2      (bus.raddr2),
    .ren2        (bus.ren2),
    .issue_valid (bus.issue_valid),
    .issue_wen   (bus.issue_wen),
    .issue_addr  (bus.issue_addr),
    .stall       (bus.stall),
    .busy_vec    (bus.busy_vec)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed scenarios plus random traffic, checked against a
// register/pending-set model through an expectation queue drained by a monitor.
module tb_wb_regfile;

  localparam int unsigned A = 5;
  localparam int unsigned D = 32;
  localparam int unsigned N = 2 ** A;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_regfile_if #(.ASIZE(A), .DSIZE(D)) bus ();

  wb_regfile #(
    .ASIZE (A),
    .DSIZE (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [D-1:0] r1;
    logic [D-1:0] r2;
    logic         stall;
    logic [N-1:0] busy;
  } exp_t;

  exp_t         exp_q[$];
  logic [D-1:0] model_r [N];
  bit           pending [int];
  int           compared   = 0;
  int           mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, away from posedge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rdata1", 64'(bus.rdata1), 64'(e.r1));
      check("rdata2", 64'(bus.rdata2), 64'(e.r2));
      check("stall", 64'(bus.stall), 64'(e.stall));
      check("busy_vec", 64'(bus.busy_vec), 64'(e.busy));
    end
  end

  function automatic logic [D-1:0] read_exp(input int a, input bit w, input int wa,
                                            input logic [D-1:0] wd);
    if (a == 0) return '0;
    if (w && wa == a) return wd;
    return model_r[a];
  endfunction

  function automatic logic [N-1:0] busy_exp();
    logic [N-1:0] b;
    b = '0;
    for (int i = 0; i < int'(N); i++) b[i] = pending.exists(i);
    return b;
  endfunction

  // A register is blocking if it has a pending producer that is not retiring now.
  function automatic bit blocked(input int a, input bit w, input int wa);
    return (a != 0) && pending.exists(a) && !(w && wa == a);
  endfunction

  task automatic cycle(input bit r, input bit w, input int wa, input logic [D-1:0] wd,
                       input int a1, input bit e1, input int a2, input bit e2,
                       input bit iv, input bit iw, input int ia);
    exp_t e;
    bit   st;
    @(posedge clk);
    #1;
    rst             = r;
    bus.wen         = w;
    bus.waddr       = wa[A-1:0];
    bus.wdata       = wd;
    bus.raddr1      = a1[A-1:0];
    bus.ren1        = e1;
    bus.raddr2      = a2[A-1:0];
    bus.ren2        = e2;
    bus.issue_valid = iv;
    bus.issue_wen   = iw;
    bus.issue_addr  = ia[A-1:0];

    st = iv && ((e1 && blocked(a1, w, wa)) || (e2 && blocked(a2, w, wa)) ||
                (iw && blocked(ia, w, wa)));
    e.r1    = read_exp(a1, w, wa, wd);
    e.r2    = read_exp(a2, w, wa, wd);
    e.stall = st;
    e.busy  = busy_exp();
    exp_q.push_back(e);

    // Model the effect of the coming clock edge.
    if (r) begin
      for (int i = 0; i < int'(N); i++) model_r[i] = '0;
      pending.delete();
    end else begin
      if (w && wa != 0) begin
        model_r[wa] = wd;
        pending.delete(wa);
      end
      if (iv && !st && iw && ia != 0) pending[ia] = 1'b1;
    end
  endtask

  task automatic idle(input int a1);
    cycle(0, 0, 0, '0, a1, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < int'(N); i++) model_r[i] = '0;
    rst             = 1'b1;
    bus.wen         = 1'b0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.raddr1      = '0;
    bus.ren1        = 1'b0;
    bus.raddr2      = '0;
    bus.ren2        = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_wen   = 1'b0;
    bus.issue_addr  = '0;
    repeat (2) @(posedge clk);

    // Reset after a preload of R5.
    cycle(0, 1, 5, 32'hA5, 0, 0, 0, 0, 0, 0, 0);
    idle(5);
    cycle(1, 0, 0, '0, 5, 1, 0, 0, 0, 0, 0);
    idle(5);

    // Write-through bypass, then storage read.
    cycle(0, 1, 3, 32'h1234, 3, 1, 0, 0, 0, 0, 0);
    idle(3);

    // RAW on R7 until writeback retires it.
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 7);
    repeat (3) cycle(0, 0, 0, '0, 7, 1, 0, 0, 1, 0, 0);
    cycle(0, 1, 7, 32'h55, 7, 1, 0, 0, 1, 0, 0);
    idle(7);

    // WAW on R4 and same-cycle retire + accept.
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 4);
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 4);
    cycle(0, 1, 4, 32'hBEEF, 0, 0, 4, 1, 1, 1, 4);
    idle(4);

    // R0 is never written and never busy.
    cycle(0, 1, 0, 32'hFF, 0, 1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, '0, 0, 1, 0, 1, 1, 1, 0);
    idle(0);

    // Reset in the middle of activity drops the write and clears busy bits.
    cycle(0, 0, 0, '0, 0, 0, 0, 0, 1, 1, 2);
    cycle(1, 1, 9, 32'hCAFE, 9, 1, 2, 1, 1, 1, 3);
    idle(9);

    // Random traffic over a small address window so hazards are frequent.
    for (int k = 0; k < 500; k++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
            int'($urandom_range(0, 7)), $urandom(),
            int'($urandom_range(0, 7)), $urandom_range(0, 1),
            int'($urandom_range(0, 7)), $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            int'($urandom_range(0, 7)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
